// File: rtl/arb_fifo_bridge_if.sv
// rtl/arb_fifo_bridge_if.sv - handshake, flag and statistics bundle for arb_fifo_bridge
//
// Purpose : groups the arbiter-side write port, the consumer-side FWFT read port,
//           the occupancy flags and the monitoring counters into one bundle.
// Ports   : ARB_WRITE/ARB_DATA/ARB_READY   arbiter word input and back-pressure
//           OUT_VALID/OUT_DATA/OUT_READ    head-of-buffer word and pop strobe
//           FIFO_FULL/FIFO_NEAR_FULL       occupancy flags (TLU veto)
//           OCCUPANCY/MAX_OCCUPANCY        current and high-watermark word count
//           LOST_CNT/CLR_STATS             dropped-word counter and statistics clear
// Modports: slave  = bridge side, master = arbiter/consumer/monitor side.
interface arb_fifo_bridge_if #(
    parameter int AW = 4
);
    logic          ARB_WRITE;
    logic [31:0]   ARB_DATA;
    logic          ARB_READY;
    logic          OUT_VALID;
    logic [31:0]   OUT_DATA;
    logic          OUT_READ;
    logic          FIFO_FULL;
    logic          FIFO_NEAR_FULL;
    logic [AW:0]   OCCUPANCY;
    logic [AW:0]   MAX_OCCUPANCY;
    logic [15:0]   LOST_CNT;
    logic          CLR_STATS;

    modport slave (
        input  ARB_WRITE, ARB_DATA, OUT_READ, CLR_STATS,
        output ARB_READY, OUT_VALID, OUT_DATA, FIFO_FULL, FIFO_NEAR_FULL,
               OCCUPANCY, MAX_OCCUPANCY, LOST_CNT
    );

    modport master (
        output ARB_WRITE, ARB_DATA, OUT_READ, CLR_STATS,
        input  ARB_READY, OUT_VALID, OUT_DATA, FIFO_FULL, FIFO_NEAR_FULL,
               OCCUPANCY, MAX_OCCUPANCY, LOST_CNT
    );
endinterface

// File: rtl/arb_fifo_bridge.sv
// rtl/arb_fifo_bridge.sv - FWFT elastic buffer between core arbiter and readout stage
//
// Purpose : stores 32-bit arbiter words in a first-word-fall-through buffer of DEPTH
//           words (output register + DEPTH-1 memory slots), presents them with a
//           valid/read handshake, drives full/near-full flags back to the core and
//           keeps occupancy, high-watermark and lost-word statistics.
// Ports   : BUS_CLK    single clock
//           BUS_RST_N  asynchronous active-low reset
//           bus        arb_fifo_bridge_if.slave (see interface for member list)
module arb_fifo_bridge #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int NEAR_FULL_THR = 12
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST_N,
    arb_fifo_bridge_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,   // nothing held, output register invalid
        ST_HEAD   = 2'd1,   // only the output register holds a word
        ST_STREAM = 2'd2    // output register valid, memory holds further words
    } state_t;

    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] OCC_NEAR = (AW+1)'(NEAR_FULL_THR);

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [AW:0]   max_q, max_d;
    logic          full_q, full_d;
    logic          near_q, near_d;
    logic [15:0]   lost_q, lost_d;

    logic [31:0]   mem [DEPTH];
    logic          mem_we;
    logic          ready;
    logic          push;
    logic          pop;

    // Ready comes from the registered count only, so OUT_READ never reaches it.
    assign ready = (occ_q != OCC_FULL);
    assign push  = bus.ARB_WRITE & ready;
    assign pop   = bus.OUT_READ & valid_q;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_we   = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    data_d  = bus.ARB_DATA;
                    valid_d = 1'b1;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (push && pop) begin
                    data_d = bus.ARB_DATA;
                end else if (push) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    state_d  = ST_STREAM;
                end else if (pop) begin
                    valid_d = 1'b0;
                    state_d = ST_EMPTY;
                end
            end
            ST_STREAM: begin
                if (push) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    data_d   = mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    // Last memory word moved into the output register.
                    if (!push && ((rd_ptr_q + AW'(1)) == wr_ptr_q)) begin
                        state_d = ST_HEAD;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
                valid_d = 1'b0;
            end
        endcase

        occ_d  = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        full_d = (occ_d == OCC_FULL);
        near_d = (occ_d >= OCC_NEAR);

        // Clear wins; the watermark then re-acquires the live count next cycle.
        if (bus.CLR_STATS) begin
            max_d = '0;
        end else if (occ_d > max_q) begin
            max_d = occ_d;
        end else begin
            max_d = max_q;
        end

        if (bus.CLR_STATS) begin
            lost_d = '0;
        end else if (bus.ARB_WRITE && !ready && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end else begin
            lost_d = lost_q;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q  <= ST_EMPTY;
            valid_q  <= 1'b0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            max_q    <= '0;
            full_q   <= 1'b0;
            near_q   <= 1'b0;
            lost_q   <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            max_q    <= max_d;
            full_q   <= full_d;
            near_q   <= near_d;
            lost_q   <= lost_d;
        end
    end

    // Storage needs no reset: pointers and state decide which entries are live.
    always_ff @(posedge BUS_CLK) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= bus.ARB_DATA;
        end
    end

    assign bus.ARB_READY      = ready;
    assign bus.OUT_VALID      = valid_q;
    assign bus.OUT_DATA       = data_q;
    assign bus.FIFO_FULL      = full_q;
    assign bus.FIFO_NEAR_FULL = near_q;
    assign bus.OCCUPANCY      = occ_q;
    assign bus.MAX_OCCUPANCY  = max_q;
    assign bus.LOST_CNT       = lost_q;

endmodule

// File: tb/tb_arb_fifo_bridge.sv
// tb/tb_arb_fifo_bridge.sv - directed self-checking bench for arb_fifo_bridge
module tb_arb_fifo_bridge;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arb_fifo_bridge_if #(.AW(4)) bus ();

    arb_fifo_bridge #(
        .DEPTH(16),
        .AW(4),
        .NEAR_FULL_THR(12)
    ) dut (
        .BUS_CLK  (clk),
        .BUS_RST_N(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.OUT_VALID), 32'd0);
        chk({tag, "_data"},  bus.OUT_DATA, 32'd0);
        chk({tag, "_occ"},   32'(bus.OCCUPANCY), 32'd0);
        chk({tag, "_max"},   32'(bus.MAX_OCCUPANCY), 32'd0);
        chk({tag, "_lost"},  32'(bus.LOST_CNT), 32'd0);
        chk({tag, "_full"},  32'(bus.FIFO_FULL), 32'd0);
        chk({tag, "_near"},  32'(bus.FIFO_NEAR_FULL), 32'd0);
        chk({tag, "_ready"}, 32'(bus.ARB_READY), 32'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.ARB_WRITE = 1'b0;
        bus.ARB_DATA  = '0;
        bus.OUT_READ  = 1'b0;
        bus.CLR_STATS = 1'b0;

        step();
        step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // 1: single push, one-cycle latency
        bus.ARB_WRITE = 1'b1;
        bus.ARB_DATA  = 32'hA5A5_0001;
        step();
        bus.ARB_WRITE = 1'b0;
        chk("t1_valid", 32'(bus.OUT_VALID), 32'd1);
        chk("t1_data",  bus.OUT_DATA, 32'hA5A5_0001);
        chk("t1_occ",   32'(bus.OCCUPANCY), 32'd1);
        bus.OUT_READ = 1'b1;
        step();
        bus.OUT_READ = 1'b0;
        chk("t1_empty_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("t1_empty_occ",   32'(bus.OCCUPANCY), 32'd0);
        chk("t1_max",         32'(bus.MAX_OCCUPANCY), 32'd1);
        // read while empty is ignored
        bus.OUT_READ = 1'b1;
        step();
        bus.OUT_READ = 1'b0;
        chk("t1_ignored_read_occ", 32'(bus.OCCUPANCY), 32'd0);

        // 2: fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) begin
            bus.ARB_WRITE = 1'b1;
            bus.ARB_DATA  = 32'(i);
            step();
            chk($sformatf("t2_near_%0d", i), 32'(bus.FIFO_NEAR_FULL), (i + 1 >= 12) ? 32'd1 : 32'd0);
            chk($sformatf("t2_full_%0d", i), 32'(bus.FIFO_FULL), (i + 1 == 16) ? 32'd1 : 32'd0);
        end
        chk("t2_ready_full", 32'(bus.ARB_READY), 32'd0);
        chk("t2_occ_full",   32'(bus.OCCUPANCY), 32'd16);
        bus.ARB_DATA = 32'h0000_0099;
        step();
        bus.ARB_WRITE = 1'b0;
        chk("t2_lost",     32'(bus.LOST_CNT), 32'd1);
        chk("t2_occ_ovf",  32'(bus.OCCUPANCY), 32'd16);
        chk("t2_head_ovf", bus.OUT_DATA, 32'd0);
        bus.OUT_READ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_drain_valid_%0d", i), 32'(bus.OUT_VALID), 32'd1);
            chk($sformatf("t2_drain_data_%0d", i), bus.OUT_DATA, 32'(i));
            step();
        end
        bus.OUT_READ = 1'b0;
        chk("t2_drained_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("t2_drained_occ",   32'(bus.OCCUPANCY), 32'd0);
        chk("t2_max",           32'(bus.MAX_OCCUPANCY), 32'd16);

        // 3: push and pop every cycle for 100 words
        bus.OUT_READ  = 1'b1;
        bus.ARB_WRITE = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.ARB_DATA = 32'h1000 + 32'(i);
            step();
            chk($sformatf("t3_occ_%0d", i),  32'(bus.OCCUPANCY), 32'd1);
            chk($sformatf("t3_data_%0d", i), bus.OUT_DATA, 32'h1000 + 32'(i));
        end
        bus.ARB_WRITE = 1'b0;
        step();
        bus.OUT_READ = 1'b0;
        chk("t3_final_occ", 32'(bus.OCCUPANCY), 32'd0);
        chk("t3_lost",      32'(bus.LOST_CNT), 32'd1);

        // 4: full buffer with simultaneous push and pop
        bus.ARB_WRITE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.ARB_DATA = 32'h200 + 32'(i);
            step();
        end
        chk("t4_full", 32'(bus.FIFO_FULL), 32'd1);
        bus.ARB_DATA = 32'hDEAD;
        bus.OUT_READ = 1'b1;
        step();
        bus.ARB_WRITE = 1'b0;
        bus.OUT_READ  = 1'b0;
        chk("t4_lost",  32'(bus.LOST_CNT), 32'd2);
        chk("t4_occ",   32'(bus.OCCUPANCY), 32'd15);
        chk("t4_head",  bus.OUT_DATA, 32'h201);
        chk("t4_full_after", 32'(bus.FIFO_FULL), 32'd0);
        chk("t4_ready", 32'(bus.ARB_READY), 32'd1);
        bus.ARB_WRITE = 1'b1;
        bus.ARB_DATA  = 32'h210;
        step();
        chk("t4_refull", 32'(bus.OCCUPANCY), 32'd16);

        // 5: lost-counter saturation and statistics clear
        bus.ARB_DATA = 32'hBAD0;
        for (int i = 0; i < 65540; i++) begin
            step();
        end
        bus.ARB_WRITE = 1'b0;
        chk("t5_lost_sat", 32'(bus.LOST_CNT), 32'h0000_FFFF);
        chk("t5_occ",      32'(bus.OCCUPANCY), 32'd16);
        bus.CLR_STATS = 1'b1;
        step();
        bus.CLR_STATS = 1'b0;
        chk("t5_lost_clr", 32'(bus.LOST_CNT), 32'd0);
        chk("t5_max_clr",  32'(bus.MAX_OCCUPANCY), 32'd0);
        step();
        chk("t5_max_restart", 32'(bus.MAX_OCCUPANCY), 32'd16);

        // 6: asynchronous reset with 8 words buffered
        bus.OUT_READ = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        bus.OUT_READ = 1'b0;
        chk("t6_occ8", 32'(bus.OCCUPANCY), 32'd8);
        chk("t6_head", bus.OUT_DATA, 32'h209);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        step();
        rst_n = 1'b1;
        step();
        bus.ARB_WRITE = 1'b1;
        bus.ARB_DATA  = 32'h600D_0001;
        step();
        bus.ARB_WRITE = 1'b0;
        chk("t6_post_valid", 32'(bus.OUT_VALID), 32'd1);
        chk("t6_post_data",  bus.OUT_DATA, 32'h600D_0001);
        chk("t6_post_occ",   32'(bus.OCCUPANCY), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
